chan_arb_reg: RTL and testbench
===============================

Name: chan_arb_reg

Overview:
- Parametrised N-channel arbitrating register slice.
- Selects one of NCH valid/ready input channels per cycle and registers its beat into a single output stage.
- Supports fixed-priority or round-robin arbitration, and packet locking on a per-channel last flag.
- Sits between multiple producers and one shared consumer (shared bus/port); successor to the single-channel always_ff register stages.

Parameters:
- WIDTH, 8, data bits per beat.
- NCH, 4, number of input channels (≥2).
- CW, $clog2(NCH), channel index width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- mode_rr  input  1  0 = fixed priority (lowest index wins), 1 = round-robin.
- in_valid  input  NCH  per-channel beat valid.
- in_last  input  NCH  per-channel last beat of packet.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NCH  per-channel accept; one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered beat.
- out_last  output  1  registered last flag.
- out_chan  output  CW  source channel of the registered beat.
- out_ready  input  1  consumer accept.

Behaviour:
- Reset, asynchronous on rst high, takes effect immediately:
  - out_valid=0, out_data=0, out_last=0, out_chan=0.
  - State machine = IDLE; rr_ptr = NCH-1, so the first round-robin search starts at channel 0; lock_chan=0.
- Output stage is empty-or-draining when !out_valid || out_ready; call this `load`.
- Grant, combinational:
  - IDLE, mode_rr=0: lowest i with in_valid[i].
  - IDLE, mode_rr=1: first valid i searching rr_ptr+1, rr_ptr+2, … modulo NCH (wrap-around).
  - LOCKED: grant only lock_chan, and only if in_valid[lock_chan]. Other channels get no grant even if valid.
- in_ready[i] = grant[i] && load. At most one bit set; all zero when no valid input or output stalled.
- Transfer on channel g (in_valid[g] && in_ready[g]):
  - Next cycle: out_data=in_data[g], out_last=in_last[g], out_chan=g, out_valid=1.
  - Latency in→out is 1 cycle.
- If load and no transfer: out_valid←0 next cycle, and data/last/chan hold their values.
- Back-to-back transfers with out_ready=1 give full throughput of one beat per cycle.
- out_ready=0 with out_valid=1: all outputs hold; in_ready all 0.
- State machine:
  - IDLE→LOCKED on transfer with in_last[g]=0; lock_chan←g.
  - LOCKED→IDLE on transfer with in_last[lock_chan]=1.
  - Transfer with last=1 in IDLE stays IDLE (single-beat packet).
- rr_ptr←g on every transfer that ends a packet (last=1), in both modes. rr_ptr is not updated mid-packet.
- mode_rr change: sampled combinationally; affects the next IDLE arbitration only. An active lock is never broken by a mode change.
- Reset mid-packet: lock is dropped and any registered beat is discarded; no partial-packet recovery.
- in_valid dropping while LOCKED is legal: stalls with no grant, lock held.

Decomposition:
- Shared package chan_arb_pkg:
  - typedef enum logic {IDLE, LOCKED} arb_state_e.
  - Function rr_pick(valid, ptr) returning the one-hot grant.
- One sub-module is natural: rr_arbiter (combinational grant from valid vector, pointer, mode), reused by other multi-source blocks.
- All state lives in chan_arb_reg's always_ff with case on state.

Test Plan:
- Reset, then mode_rr=0, in_valid=4'b1010, all last=1, out_ready=1 → in_ready=4'b0010; next cycle out_chan=1, out_valid=1; repeats channel 1 every cycle (channel 3 starves).
- mode_rr=1, in_valid=4'b1111 constant, last=1, out_ready=1 → out_chan sequence 0,1,2,3,0 on consecutive cycles.
- mode_rr=1, channel 2 sends 3 beats (last on 3rd) while channels 0,3 valid → out_chan 2,2,2, then 3, then 0; in_ready[0],[3]=0 during lock.
- out_valid=1, out_ready=0 for 3 cycles with in_valid=4'b0001 → in_ready=0; out_data stable; after out_ready=1 the next beat appears 1 cycle later with no loss or duplication.
- rst asserted mid-packet (LOCKED on ch1) between clock edges → outputs 0 immediately; after release, in_valid=4'b0001 granted (lock cleared, rr_ptr=3).
- NCH=3, WIDTH=16 instance, mode_rr=1, in_valid=3'b111 → out_chan 0,1,2,0 (non-power-of-two wrap), data bits [i*16 +: 16] routed correctly.

Source files
------------

// File: rtl/chan_arb_pkg.sv
// chan_arb_pkg: shared types and helpers for the arbitrating register slice.
//   arb_state_e : packet-lock state (IDLE / LOCKED).
//   rr_pick()   : one-hot round-robin pick over up to MAX_NCH requesters.
package chan_arb_pkg;

    localparam int unsigned MAX_NCH = 32;

    typedef enum logic {IDLE, LOCKED} arb_state_e;

    // Search ptr+1, ptr+2, ... modulo nch; first valid requester wins.
    function automatic logic [MAX_NCH-1:0] rr_pick(input logic [MAX_NCH-1:0] valid,
                                                   input int unsigned        ptr,
                                                   input int unsigned        nch);
        logic        found;
        int unsigned idx;
        rr_pick = '0;
        found   = 1'b0;
        for (int unsigned k = 1; k <= nch; k++) begin
            idx = (ptr + k) % nch;
            if (!found && valid[idx]) begin
                rr_pick[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational one-hot grant from a request vector.
//   mode_rr : 0 = fixed priority (lowest index), 1 = round-robin after ptr.
//   valid   : per-requester request.
//   ptr     : index of the last requester served (round-robin origin).
//   grant   : one-hot grant, zero when nothing requests.
module rr_arbiter
    import chan_arb_pkg::*;
#(
    parameter  int NCH = 4,
    localparam int CW  = $clog2(NCH)
) (
    input  logic            mode_rr,
    input  logic [NCH-1:0]  valid,
    input  logic [CW-1:0]   ptr,
    output logic [NCH-1:0]  grant
);

    always_comb begin
        grant = '0;
        if (mode_rr) begin
            grant = NCH'(rr_pick(MAX_NCH'(valid), 32'(ptr), 32'(NCH)));
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (valid[i] && (grant == '0)) grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chan_arb_reg.sv
// chan_arb_reg: NCH-channel arbitrating register slice with packet locking.
//   clk, rst    : rising-edge clock, asynchronous active-high reset.
//   mode_rr     : 0 = fixed priority, 1 = round-robin.
//   in_valid/in_last/in_data : per-channel beat (channel i at [i*WIDTH +: WIDTH]).
//   in_ready    : per-channel accept, one-hot or zero.
//   out_valid/out_data/out_last/out_chan : registered beat and its source.
//   out_ready   : consumer accept.
module chan_arb_reg
    import chan_arb_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    localparam int CW    = $clog2(NCH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode_rr,
    input  logic [NCH-1:0]        in_valid,
    input  logic [NCH-1:0]        in_last,
    input  logic [NCH*WIDTH-1:0]  in_data,
    output logic [NCH-1:0]        in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_last,
    output logic [CW-1:0]         out_chan,
    input  logic                  out_ready
);

    arb_state_e     state, state_next;
    logic [CW-1:0]  rr_ptr;
    logic [CW-1:0]  lock_chan;
    logic [NCH-1:0] arb_grant;
    logic [NCH-1:0] grant;
    logic [CW-1:0]  g;
    logic           load;
    logic           xfer;
    logic           sel_last;
    logic [WIDTH-1:0] sel_data;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .mode_rr (mode_rr),
        .valid   (in_valid),
        .ptr     (rr_ptr),
        .grant   (arb_grant)
    );

    assign load = !out_valid || out_ready;

    // While locked only the owning channel may be granted; the free arbiter is ignored.
    always_comb begin
        grant = '0;
        if (state == LOCKED) grant[lock_chan] = in_valid[lock_chan];
        else                 grant = arb_grant;
    end

    assign in_ready = load ? grant : '0;
    assign xfer     = |(in_valid & in_ready);

    always_comb begin
        g = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (grant[i]) g = CW'(i);
        end
    end

    assign sel_data = in_data[g*WIDTH +: WIDTH];
    assign sel_last = in_last[g];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (xfer && !sel_last) state_next = LOCKED;
            LOCKED:  if (xfer && sel_last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= CW'(NCH - 1);
            lock_chan <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_chan  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE:    if (xfer && !sel_last) lock_chan <= g;
                default: ;
            endcase
            if (xfer && sel_last) rr_ptr <= g;
            if (load) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= sel_data;
                    out_last <= sel_last;
                    out_chan <= g;
                end
            end
        end
    end

endmodule

// File: tb/tb_chan_arb_reg.sv
module tb_chan_arb_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode_rr = 1'b0;
    logic [3:0]  in_valid = '0;
    logic [3:0]  in_last = '0;
    logic [31:0] in_data = '0;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic [1:0]  out_chan;
    logic        out_ready = 1'b1;

    logic [2:0]  in_valid2 = '0;
    logic [2:0]  in_last2 = '0;
    logic [47:0] in_data2 = '0;
    logic [2:0]  in_ready2;
    logic        out_valid2;
    logic [15:0] out_data2;
    logic        out_last2;
    logic [1:0]  out_chan2;

    int total = 0;
    int bad   = 0;

    // Reference model state for the 4-channel instance
    bit       m_valid;
    bit [7:0] m_data;
    bit       m_last;
    int       m_chan;
    bit       m_locked;
    int       m_lch;
    int       m_ptr;

    always #5 clk = ~clk;

    chan_arb_reg #(.WIDTH(8), .NCH(4)) dut (
        .clk(clk), .rst(rst), .mode_rr(mode_rr),
        .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_chan(out_chan), .out_ready(out_ready)
    );

    chan_arb_reg #(.WIDTH(16), .NCH(3)) dut3 (
        .clk(clk), .rst(rst), .mode_rr(1'b1),
        .in_valid(in_valid2), .in_last(in_last2), .in_data(in_data2),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2),
        .out_last(out_last2), .out_chan(out_chan2), .out_ready(1'b1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_valid = 0; m_data = 0; m_last = 0; m_chan = 0;
        m_locked = 0; m_lch = 0; m_ptr = 3;
    endfunction

    // Which channel the rules say should be accepted this cycle, or -1.
    function automatic int exp_grant();
        if (m_valid && !out_ready) return -1;
        if (m_locked) return in_valid[m_lch] ? m_lch : -1;
        if (!mode_rr) begin
            for (int c = 0; c < 4; c++) if (in_valid[c]) return c;
            return -1;
        end
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_ptr + k) % 4;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    // Inputs already driven; check in_ready, clock once, update model, check outputs.
    task automatic cycle();
        int       g;
        bit [7:0] d;
        bit       l;
        #1;
        g = exp_grant();
        chk("in_ready", 64'(in_ready), (g < 0) ? 64'd0 : (64'd1 << g));
        if (g >= 0) begin d = in_data[g*8 +: 8]; l = in_last[g]; end
        @(posedge clk);
        if (!m_valid || out_ready) begin
            if (g >= 0) begin
                m_valid = 1; m_data = d; m_last = l; m_chan = g;
                if (!m_locked && !l) begin m_locked = 1; m_lch = g; end
                else if (m_locked && l) m_locked = 0;
                if (l) m_ptr = g;
            end else begin
                m_valid = 0;
            end
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("out_data",  64'(out_data),  64'(m_data));
        chk("out_last",  64'(out_last),  64'(m_last));
        chk("out_chan",  64'(out_chan),  64'(m_chan));
    endtask

    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_data"},  64'(out_data),  64'd0);
        chk({tag, "_last"},  64'(out_last),  64'd0);
        chk({tag, "_chan"},  64'(out_chan),  64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    initial begin : main
        int          seq4 [5];
        int          seq3 [4];
        logic [7:0]  held;
        logic [15:0] exp16;
        int          c3;

        seq4 = '{0, 1, 2, 3, 0};
        seq3 = '{0, 1, 2, 0};
        model_reset();
        @(posedge clk);
        #1;
        do_reset("reset");

        // Fixed priority: channel 1 wins every cycle, channel 3 starves
        mode_rr = 0; in_valid = 4'b1010; in_last = 4'b1111; out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            in_data = $urandom;
            cycle();
            chk("fp_chan1", 64'(out_chan), 64'd1);
        end

        // Round-robin rotation from a fresh reset
        do_reset("reset2");
        mode_rr = 1; in_valid = 4'b1111; in_last = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            in_data = $urandom;
            cycle();
            chk("rr_seq", 64'(out_chan), 64'(seq4[i]));
        end

        // Packet lock on channel 2 with 0 and 3 also requesting
        in_valid = 4'b0100; in_last = 4'b1011; in_data = $urandom;
        cycle();
        chk("lock_b1", 64'(out_chan), 64'd2);
        in_valid = 4'b1101; in_data = $urandom;
        cycle();
        chk("lock_b2", 64'(out_chan), 64'd2);
        in_last = 4'b1111; in_data = $urandom;
        cycle();
        chk("lock_b3", 64'(out_chan), 64'd2);
        in_data = $urandom;
        cycle();
        chk("after_lock_a", 64'(out_chan), 64'd3);
        in_data = $urandom;
        cycle();
        chk("after_lock_b", 64'(out_chan), 64'd0);

        // Backpressure: output held, nothing accepted, no loss or duplication
        held = out_data;
        in_valid = 4'b0001; in_last = 4'b1111; in_data = $urandom; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_ready", 64'(in_ready), 64'd0);
            chk("stall_data", 64'(out_data), 64'(held));
        end
        out_ready = 1;
        cycle();
        chk("resume_data", 64'(out_data), 64'(in_data[7:0]));
        in_valid = 4'b0000;
        cycle();
        chk("no_dup", 64'(out_valid), 64'd0);

        // Reset while locked on channel 1
        mode_rr = 0; in_valid = 4'b0010; in_last = 4'b0000; in_data = $urandom;
        cycle();
        do_reset("reset_mid");
        in_valid = 4'b0001; in_last = 4'b1111;
        #1 chk("post_reset_ready", 64'(in_ready), 64'd1);
        cycle();

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            in_valid  = 4'($urandom);
            in_last   = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) mode_rr = ~mode_rr;
            cycle();
        end
        out_ready = 1;

        // Three-channel instance: non-power-of-two wrap and data routing
        in_valid2 = 3'b111; in_last2 = 3'b111;
        for (int i = 0; i < 4; i++) begin
            in_data2 = {16'($urandom), 16'($urandom), 16'($urandom)};
            c3 = seq3[i];
            exp16 = in_data2[c3*16 +: 16];
            #1 chk("nch3_ready", 64'(in_ready2), 64'd1 << c3);
            @(posedge clk);
            #1;
            chk("nch3_chan", 64'(out_chan2), 64'(c3));
            chk("nch3_data", 64'(out_data2), 64'(exp16));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
